avmm_arbiter_2m: RTL and testbench
==================================

AVMM_ARBITER_2M -- requirements
Module: avmm_arbiter_2m

Interface
REQ-001 SHALL have parameter AV_ADDRESS_W, default 2, the Avalon-MM word address width.
REQ-002 SHALL have parameter AV_DATA_W, default 32, the data width.
REQ-003 SHALL have parameter AV_NUMSYMBOLS, default 4, the byteenable width.
REQ-004 SHALL have parameter TIMEOUT, default 255, the waitrequest cycle limit; 0 disables the timeout.
REQ-005 SHALL have port clk, input, 1 bit, the clock; all state on its rising edge.
REQ-006 SHALL have port rstn, input, 1 bit, the reset: asynchronous, active-low.
REQ-007 SHALL have, for i = 0 and 1, ports mi_read and mi_write, input, 1 bit each, the master i transfer request.
REQ-008 SHALL have, for i = 0 and 1, mi_address (input, AV_ADDRESS_W), mi_byteenable (input, AV_NUMSYMBOLS) and mi_writedata (input, AV_DATA_W).
REQ-009 SHALL have, for i = 0 and 1, mi_waitrequest (output, 1) and mi_readdata (output, AV_DATA_W).
REQ-010 SHALL have slave-side ports s_read, s_write (output, 1), s_address, s_byteenable, s_writedata (output, widths as above).
REQ-011 SHALL have slave-side ports s_waitrequest (input, 1) and s_readdata (input, AV_DATA_W).
REQ-012 SHALL have port timeout_err, output, 1 bit, sticky timeout flag, and port timeout_clr, input, 1 bit, which clears it.

Function
REQ-013 SHALL implement states IDLE, GNT0, GNT1 and ABORT, plus a last_grant bit and a waitrequest counter.
- Request for master i: reqi = mi_read | mi_write.
REQ-014 SHALL in IDLE drive s_read = s_write = 0 and assert m0_waitrequest = m1_waitrequest = 1.
REQ-015 SHALL in IDLE go to GNT0 if only req0, or GNT1 if only req1; grant takes effect the cycle after the request is first seen.
REQ-016 SHALL on req0 & req1 in IDLE grant the master not equal to last_grant, and update last_grant to the granted index.
REQ-017 SHALL in GNTi forward master i's read, write, address, byteenable and writedata combinationally to s_*.
- mi_waitrequest = s_waitrequest; the other master's waitrequest = 1.
REQ-018 SHALL forward read and write unchanged when both are asserted by the granted master; masters SHALL NOT do this.
REQ-019 SHALL route s_readdata combinationally to both m0_readdata and m1_readdata in every state except ABORT.
REQ-020 SHALL complete a transfer in GNTi when reqi & !s_waitrequest, then go to IDLE.
- Minimum spacing between grants is therefore one IDLE cycle.
REQ-021 SHALL go to IDLE if the granted master drops reqi before completion.
REQ-022 SHALL clear the waitrequest counter on entry to GNTi and increment it each GNTi cycle with s_waitrequest = 1.
REQ-023 SHALL go to ABORT when the counter reaches TIMEOUT (TIMEOUT != 0), setting timeout_err on the same edge.
REQ-024 SHALL in ABORT drive s_read = s_write = 0, mi_waitrequest = 0 and mi_readdata = 0 for the last-granted master, other master waitrequest = 1, then go to IDLE.
REQ-025 SHALL clear timeout_err on timeout_clr; a simultaneous set wins over clear.
REQ-026 SHALL not let the counter wrap: width is clog2(TIMEOUT+1), saturating at TIMEOUT.

Reset
REQ-027 SHALL on rstn low asynchronously enter IDLE, last_grant = 1 (m0 wins the first tie), counter = 0 and timeout_err = 0.
- Outputs then: s_read = s_write = 0, mi_waitrequest = 1.
REQ-028 SHALL on reset mid-transfer abandon the transfer without any completion signalling to either master.

Structure
REQ-029 SHALL take the state enum typedef and default parameter constants from shared package avmm_arb_pkg.
REQ-030 SHALL place the tie-break/round-robin pick logic in sub-module avmm_arb_rr_pick (inputs req0, req1, last_grant; outputs gnt_valid, gnt_idx).

Verification
REQ-031 m0 writes addr 0 data 0x010a, slave waitrequest 1 cycle -> s_write seen 2 cycles; m0_waitrequest low on the second; m1_waitrequest stays 1.
REQ-032 m0 and m1 both read in the same cycle after reset -> m0 granted first, m1 granted after one IDLE cycle; each sees its own s_readdata (0x0000010a, 0x0000010f).
REQ-033 Both masters hold continuous requests for 6 transfers -> grants alternate 0,1,0,1,0,1.
REQ-034 TIMEOUT = 4, slave holds waitrequest -> ABORT after 4 wait cycles; master gets waitrequest 0 with readdata 0; timeout_err = 1 until timeout_clr.
REQ-035 Assert rstn low while in GNT1 -> IDLE immediately: s_read = 0, both waitrequests 1, then m0 wins the next tie.

Source files
------------

// File: rtl/avmm_arb_pkg.sv
// Shared types and default constants for the two-master Avalon-MM arbiter.
package avmm_arb_pkg;

  localparam int DEF_AV_ADDRESS_W  = 2;
  localparam int DEF_AV_DATA_W     = 32;
  localparam int DEF_AV_NUMSYMBOLS = 4;
  localparam int DEF_TIMEOUT       = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  // A zero timeout still needs a 1-bit counter to keep the declarations legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/avmm_arb_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that was not granted last.
module avmm_arb_rr_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_idx
);

  assign gnt_valid = req0 | req1;
  assign gnt_idx   = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/avmm_arbiter_2m.sv
// Two-master Avalon-MM arbiter with one IDLE cycle between grants and a
// waitrequest timeout that aborts a stuck transfer back to its master.
module avmm_arbiter_2m
  import avmm_arb_pkg::*;
#(
  parameter int AV_ADDRESS_W  = DEF_AV_ADDRESS_W,
  parameter int AV_DATA_W     = DEF_AV_DATA_W,
  parameter int AV_NUMSYMBOLS = DEF_AV_NUMSYMBOLS,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     m0_read,
  input  logic                     m0_write,
  input  logic [AV_ADDRESS_W-1:0]  m0_address,
  input  logic [AV_NUMSYMBOLS-1:0] m0_byteenable,
  input  logic [AV_DATA_W-1:0]     m0_writedata,
  output logic                     m0_waitrequest,
  output logic [AV_DATA_W-1:0]     m0_readdata,
  input  logic                     m1_read,
  input  logic                     m1_write,
  input  logic [AV_ADDRESS_W-1:0]  m1_address,
  input  logic [AV_NUMSYMBOLS-1:0] m1_byteenable,
  input  logic [AV_DATA_W-1:0]     m1_writedata,
  output logic                     m1_waitrequest,
  output logic [AV_DATA_W-1:0]     m1_readdata,
  output logic                     s_read,
  output logic                     s_write,
  output logic [AV_ADDRESS_W-1:0]  s_address,
  output logic [AV_NUMSYMBOLS-1:0] s_byteenable,
  output logic [AV_DATA_W-1:0]     s_writedata,
  input  logic                     s_waitrequest,
  input  logic [AV_DATA_W-1:0]     s_readdata,
  output logic                     timeout_err,
  input  logic                     timeout_clr
);

  localparam int              CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             timeout_set;

  logic req0, req1, gnt_req;
  logic gnt_valid, gnt_idx;

  assign req0    = m0_read | m0_write;
  assign req1    = m1_read | m1_write;
  assign gnt_req = (state_q == GNT1) ? req1 : req0;

  avmm_arb_rr_pick u_rr_pick (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    timeout_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d      = gnt_idx ? GNT1 : GNT0;
          last_grant_d = gnt_idx;
          cnt_d        = '0;
        end
      end
      GNT0, GNT1: begin
        if (!gnt_req || !s_waitrequest) begin
          state_d = IDLE;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if ((TIMEOUT != 0) && (cnt_d == CNT_MAX)) begin
            state_d     = ABORT;
            timeout_set = 1'b1;
          end
        end
      end
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A timeout landing on the same edge as a clear keeps the flag set.
  assign timeout_err_d = timeout_set | (timeout_err_q & ~timeout_clr);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

  always_comb begin
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_address      = '0;
    s_byteenable   = '0;
    s_writedata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    m0_readdata    = s_readdata;
    m1_readdata    = s_readdata;
    case (state_q)
      GNT0: begin
        s_read         = m0_read;
        s_write        = m0_write;
        s_address      = m0_address;
        s_byteenable   = m0_byteenable;
        s_writedata    = m0_writedata;
        m0_waitrequest = s_waitrequest;
      end
      GNT1: begin
        s_read         = m1_read;
        s_write        = m1_write;
        s_address      = m1_address;
        s_byteenable   = m1_byteenable;
        s_writedata    = m1_writedata;
        m1_waitrequest = s_waitrequest;
      end
      ABORT: begin
        // Release the stuck master with an all-zero read response.
        m0_readdata = '0;
        m1_readdata = '0;
        if (last_grant_q) m1_waitrequest = 1'b0;
        else              m0_waitrequest = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avmm_arbiter_2m.sv
// Directed bench for avmm_arbiter_2m: stimulus pushes expected responses,
// a negedge monitor pops and compares them as transfers complete.
module tb_avmm_arbiter_2m;

  typedef struct {
    bit          chk;
    logic [31:0] rd;
  } exp_m_t;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wd;
  } exp_s_t;

  logic clk;
  logic rstn;

  logic [1:0]       mrd, mwr;
  logic [1:0][1:0]  maddr;
  logic [1:0][3:0]  mbe;
  logic [1:0][31:0] mwd;
  wire  [1:0]       mwait;
  wire  [1:0][31:0] mrdata;

  wire         s_read, s_write;
  wire  [1:0]  s_address;
  wire  [3:0]  s_byteenable;
  wire  [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  wire         timeout_err;
  logic        timeout_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cyc [2];

  exp_m_t exp_m [2][$];
  exp_s_t exp_s [$];
  int     exp_gnt [$];

  logic [31:0] rd_mem [4];
  int          wait_cfg = 0;
  int          wait_cnt;

  avmm_arbiter_2m #(
    .AV_ADDRESS_W  (2),
    .AV_DATA_W     (32),
    .AV_NUMSYMBOLS (4),
    .TIMEOUT       (4)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .m0_read        (mrd[0]),
    .m0_write       (mwr[0]),
    .m0_address     (maddr[0]),
    .m0_byteenable  (mbe[0]),
    .m0_writedata   (mwd[0]),
    .m0_waitrequest (mwait[0]),
    .m0_readdata    (mrdata[0]),
    .m1_read        (mrd[1]),
    .m1_write       (mwr[1]),
    .m1_address     (maddr[1]),
    .m1_byteenable  (mbe[1]),
    .m1_writedata   (mwd[1]),
    .m1_waitrequest (mwait[1]),
    .m1_readdata    (mrdata[1]),
    .s_read         (s_read),
    .s_write        (s_write),
    .s_address      (s_address),
    .s_byteenable   (s_byteenable),
    .s_writedata    (s_writedata),
    .s_waitrequest  (s_waitrequest),
    .s_readdata     (s_readdata),
    .timeout_err    (timeout_err),
    .timeout_clr    (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: wait_cfg waitrequest cycles per transfer, fixed read table.
  assign s_waitrequest = (s_read | s_write) && (wait_cnt < wait_cfg);
  assign s_readdata    = rd_mem[s_address];

  always @(posedge clk or negedge rstn) begin
    if (!rstn)                                          wait_cnt <= 0;
    else if ((s_read | s_write) && wait_cnt < wait_cfg) wait_cnt <= wait_cnt + 1;
    else                                                wait_cnt <= 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: any master seeing waitrequest low while requesting is a response.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 2; i++) begin
        if ((mrd[i] | mwr[i]) && !mwait[i]) begin
          exp_m_t e;
          done_cyc[i] <= cyc;
          if (exp_gnt.size() == 0) check("gnt_unexpected", 32'(i), 32'hff);
          else                     check("gnt_order", 32'(i), 32'(exp_gnt.pop_front()));
          if (exp_m[i].size() == 0) begin
            check($sformatf("m%0d_resp_unexpected", i), 32'(i), 32'hff);
          end else begin
            e = exp_m[i].pop_front();
            if (e.chk) check($sformatf("m%0d_readdata", i), mrdata[i], e.rd);
          end
        end
      end
      if (s_write && !s_waitrequest) begin
        exp_s_t s;
        if (exp_s.size() == 0) begin
          check("s_write_unexpected", 32'(s_address), 32'hff);
        end else begin
          s = exp_s.pop_front();
          check("s_address", 32'(s_address), 32'(s.addr));
          check("s_writedata", s_writedata, s.wd);
        end
      end
    end
  end

  // Runs n back-to-back transfers holding the request; called at posedge+1.
  task automatic m_xfer(input int idx, input bit wr, input logic [1:0] addr0,
                        input logic [31:0] wd0, input int n, input bit aborted);
    logic [1:0] a;
    bit         ok;
    a = addr0;
    for (int k = 0; k < n; k++) begin
      exp_m[idx].push_back('{chk: !wr, rd: aborted ? 32'h0 : rd_mem[a]});
      if (wr) exp_s.push_back('{addr: a, wd: wd0 + 32'(k)});
      mrd[idx]   = !wr;
      mwr[idx]   = wr;
      maddr[idx] = a;
      mbe[idx]   = 4'hf;
      mwd[idx]   = wd0 + 32'(k);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        @(negedge clk);
        ok = !mwait[idx];
        @(posedge clk);
        #1;
      end
      check($sformatf("m%0d_xfer_done", idx), 32'(ok), 32'd1);
      a = a + 2'd1;
    end
    mrd[idx] = 1'b0;
    mwr[idx] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          wcnt;
    logic [7:0]  wpat;
    bit          m1_low;
    logic        terr_ab, sread_ab;

    rd_mem[0] = 32'h0000_0100;
    rd_mem[1] = 32'h0000_010a;
    rd_mem[2] = 32'h0000_010f;
    rd_mem[3] = 32'h0000_0155;
    rstn = 1'b0;
    mrd = '0; mwr = '0; maddr = '0; mbe = '0; mwd = '0;
    timeout_clr = 1'b0;

    // Reset state
    #3;
    check("rst_s_read", 32'(s_read), 32'd0);
    check("rst_s_write", 32'(s_write), 32'd0);
    check("rst_mwait", 32'(mwait), 32'd3);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Simultaneous reads after reset: m0 first, m1 one IDLE cycle later
    wait_cfg = 0;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      m_xfer(0, 1'b0, 2'd1, 32'h0, 1, 1'b0);
      m_xfer(1, 1'b0, 2'd2, 32'h0, 1, 1'b0);
    join
    check("tie_grant_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd2);

    // Continuous requests from both: grants alternate 0,1,0,1,0,1
    wait_cfg = 1;
    for (int k = 0; k < 3; k++) begin exp_gnt.push_back(0); exp_gnt.push_back(1); end
    fork
      m_xfer(0, 1'b0, 2'd0, 32'h0, 3, 1'b0);
      m_xfer(1, 1'b0, 2'd1, 32'h0, 3, 1'b0);
    join

    // m0 write with one slave wait cycle
    wait_cfg = 1;
    wcnt = 0; wpat = '0; m1_low = 1'b0;
    exp_gnt.push_back(0);
    fork
      m_xfer(0, 1'b1, 2'd0, 32'h0000_010a, 1, 1'b0);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (s_write) begin wcnt++; wpat = {wpat[6:0], mwait[0]}; end
        if (!mwait[1]) m1_low = 1'b1;
      end
    join
    @(posedge clk); #1;
    check("wr_s_write_cycles", 32'(wcnt), 32'd2);
    check("wr_m0_wait_pattern", 32'(wpat[1:0]), 32'd2);
    check("wr_m1_wait_held", 32'(m1_low), 32'd0);

    // Stuck slave: abort after 4 wait cycles, sticky timeout_err
    wait_cfg = 100;
    wcnt = 0; m1_low = 1'b0; terr_ab = 1'b0; sread_ab = 1'b1;
    exp_gnt.push_back(0);
    fork
      m_xfer(0, 1'b0, 2'd3, 32'h0, 1, 1'b1);
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (s_read && mwait[0]) wcnt++;
        if (mrd[0] && !mwait[0]) begin terr_ab = timeout_err; sread_ab = s_read; end
        if (!mwait[1]) m1_low = 1'b1;
      end
    join
    @(posedge clk); #1;
    check("to_wait_cycles", 32'(wcnt), 32'd4);
    check("to_err_at_abort", 32'(terr_ab), 32'd1);
    check("to_s_read_in_abort", 32'(sread_ab), 32'd0);
    check("to_m1_wait_held", 32'(m1_low), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("to_err_sticky", 32'(timeout_err), 32'd1);
    timeout_clr = 1'b1;
    @(posedge clk);
    #1 timeout_clr = 1'b0;
    check("to_err_cleared", 32'(timeout_err), 32'd0);

    // Reset while m1 is granted
    wait_cfg = 100;
    mrd[1] = 1'b1; maddr[1] = 2'd2; mbe[1] = 4'hf;
    @(posedge clk); #1;
    @(negedge clk);
    check("gnt1_s_read", 32'(s_read), 32'd1);
    check("gnt1_m1_wait", 32'(mwait[1]), 32'd1);
    #1 rstn = 1'b0;
    #1;
    check("rst_mid_s_read", 32'(s_read), 32'd0);
    check("rst_mid_mwait", 32'(mwait), 32'd3);
    mrd[1] = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    wait_cfg = 0;
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      m_xfer(0, 1'b0, 2'd1, 32'h0, 1, 1'b0);
      m_xfer(1, 1'b0, 2'd2, 32'h0, 1, 1'b0);
    join
    check("post_rst_tie_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd2);

    repeat (2) @(posedge clk);
    #1;
    check("gnt_queue_drained", 32'(exp_gnt.size()), 32'd0);
    check("m0_queue_drained", 32'(exp_m[0].size()), 32'd0);
    check("m1_queue_drained", 32'(exp_m[1].size()), 32'd0);
    check("s_queue_drained", 32'(exp_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
